dma_controller: RTL
===================

Name: dma_controller

Overview:
- Device-side end of the DMA bus-request protocol; counterpart of the CPU-side interrupt handler/arbiter.
- On a start command, raises BR, waits for BG, then writes a block of 4-word bursts from the external device buffer into data memory.
- Releases the bus after the last burst and pulses dma_end_int to the CPU.
- Sits between the device buffer, the d_mem write port (shared with the CPU via BG), and the interrupt handler.

Parameters:
- WORD_SIZE, 16, width of one memory word and of addresses.
- BURST_WORDS, 4, words per memory write; data bus width = BURST_WORDS*WORD_SIZE.
- MAX_BURSTS, 16, largest accepted burst count; sets cmd_bursts width = $clog2(MAX_BURSTS+1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- cmd  in  1  start command from the interrupt handler; level, sampled each rising edge.
- cmd_addr  in  WORD_SIZE  destination base word address, latched with cmd.
- cmd_bursts  in  $clog2(MAX_BURSTS+1)  number of bursts, latched with cmd.
- BG  in  1  bus grant from the arbiter.
- BR  out  1  bus request to the arbiter.
- dma_end_int  out  1  one-cycle transfer-complete pulse.
- dma_writeM  out  1  memory write strobe.
- dma_address  out  WORD_SIZE  burst start address.
- dma_data  out  BURST_WORDS*WORD_SIZE  burst data; word 0 in the MSBs.
- dma_doneWrite  in  1  memory write-complete acknowledge.
- dev_idx  out  $clog2(MAX_BURSTS)  index of the burst requested from the device buffer.
- dev_data  in  BURST_WORDS*WORD_SIZE  device buffer data for dev_idx; combinational from dev_idx.

Behaviour:
- Reset (reset=1 at a rising edge):
  - State goes to IDLE.
  - BR, dma_writeM and dma_end_int are 0.
  - dma_address, dma_data, dev_idx and the internal counters are 0.
  - Reset mid-transfer aborts at that edge, drops BR, and produces no end pulse.
- IDLE:
  - On cmd=1, latch cmd_addr into addr_r and cmd_bursts into remain, and clear dev_idx.
  - If cmd_bursts==0, go to DONE. BR never rises, so the end pulse follows cmd by 1 cycle.
  - Otherwise go to REQ. BR=1 from the next cycle (1-cycle latency from cmd sample).
- REQ:
  - BR=1. Wait for BG=1; BG is sampled only here.
  - Then go to WRITE and register dma_address=addr_r, dma_data=dev_data, dma_writeM=1.
- WRITE:
  - Hold BR, dma_writeM, dma_address and dma_data stable until dma_doneWrite=1.
  - On dma_doneWrite: dma_writeM=0 at the next edge, addr_r += BURST_WORDS (wraps mod 2^WORD_SIZE), remain -= 1, dev_idx += 1.
  - If remain was 1, go to RELEASE. Otherwise go to NEXT.
- NEXT:
  - One cycle with dma_writeM=0 so memory sees a fresh strobe.
  - Reload dma_address and dma_data from the new addr_r and dev_data, set dma_writeM=1, and return to WRITE. BR stays 1.
- RELEASE:
  - BR=0. Wait until BG=0; the arbiter drops BG on BR falling, usually the same cycle.
  - Then go to DONE.
- DONE:
  - dma_end_int=1 for exactly one cycle, then return to IDLE.
  - A new cmd is accepted in IDLE only, so there is always at least one BR-low cycle between transfers.
- cmd while not IDLE is ignored; there is no queueing.
- cmd held high across DONE restarts a transfer from IDLE. The CPU is responsible for deasserting it.
- BG falling while in WRITE/NEXT is a protocol violation. Behaviour is unspecified, and the bench asserts it never happens.
- dma_doneWrite outside WRITE is ignored.
- Outputs are registered; no output combinationally depends on an input.

Decomposition:
- Shared package `dma_defs`:
  - state enum IDLE, REQ, WRITE, NEXT, RELEASE, DONE
  - WORD_SIZE and BURST_WORDS constants, shared with the interrupt handler and d_mem
- No sub-module: a single FSM plus address and burst counters is natural. Optional `dma_burst_counter` only if reused elsewhere.

Test Plan:
- Basic 3-burst transfer, grant after 2 cycles:
  - Stimulus: cmd=1 for 1 cycle, cmd_addr=0x01F4, cmd_bursts=3; BG asserted 2 cycles after BR; doneWrite 3 cycles after each writeM.
  - Required: writes at 0x01F4, 0x01F8, 0x01FC with dev_idx 0, 1, 2; BR low after the third ack; one dma_end_int pulse.
- Zero-length command:
  - Stimulus: cmd_bursts=0.
  - Required: BR never rises; dma_end_int pulses 1 cycle after cmd.
- Address wrap:
  - Stimulus: cmd_addr=0xFFFC, cmd_bursts=2.
  - Required: writes at 0xFFFC then 0x0000.
- Busy command and busy memory:
  - Stimulus: cmd re-pulsed during WRITE; doneWrite held low 10 cycles.
  - Required: second cmd ignored; writeM, address and data stable all 10 cycles; exactly one end pulse.
- Reset mid-transfer:
  - Stimulus: reset during the second burst's WRITE.
  - Required: BR=0, writeM=0 and dma_end_int=0 next cycle; a following cmd runs a full transfer correctly.
- Back-to-back commands:
  - Stimulus: cmd held high across DONE.
  - Required: BR low at least 1 cycle between transfers; BG=0 observed before BR rises again.

Source files
------------

// File: rtl/dma_defs_pkg.sv
// Shared DMA definitions: FSM state codes and the memory word/burst geometry
// also used by the interrupt handler and d_mem.
package dma_defs;

    localparam int WORD_SIZE   = 16;
    localparam int BURST_WORDS = 4;
    localparam int MAX_BURSTS  = 16;

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] REQ     = 3'd1;
    localparam logic [2:0] WRITE   = 3'd2;
    localparam logic [2:0] NEXT    = 3'd3;
    localparam logic [2:0] RELEASE = 3'd4;
    localparam logic [2:0] DONE    = 3'd5;

endpackage

// File: rtl/dma_controller.sv
// Bus-request DMA: on cmd, acquires the bus, writes cmd_bursts 4-word bursts, releases the bus and pulses dma_end_int.
// BR rises 1 cycle after cmd; each burst is held until dma_doneWrite, with the bus held until BG drops after release.
import dma_defs::*;

module dma_controller #(
    parameter int WORD_SIZE   = dma_defs::WORD_SIZE,
    parameter int BURST_WORDS = dma_defs::BURST_WORDS,
    parameter int MAX_BURSTS  = dma_defs::MAX_BURSTS,
    parameter int CW          = $clog2(MAX_BURSTS + 1),
    parameter int IW          = $clog2(MAX_BURSTS)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            cmd,
    input  logic [WORD_SIZE-1:0]            cmd_addr,
    input  logic [CW-1:0]                   cmd_bursts,
    input  logic                            BG,
    output logic                            BR,
    output logic                            dma_end_int,
    output logic                            dma_writeM,
    output logic [WORD_SIZE-1:0]            dma_address,
    output logic [BURST_WORDS*WORD_SIZE-1:0] dma_data,
    input  logic                            dma_doneWrite,
    output logic [IW-1:0]                   dev_idx,
    input  logic [BURST_WORDS*WORD_SIZE-1:0] dev_data
);

    logic [2:0]           state;
    logic [WORD_SIZE-1:0] addr_r;
    logic [CW-1:0]        remain;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            addr_r      <= '0;
            remain      <= '0;
            dev_idx     <= '0;
            BR          <= 1'b0;
            dma_end_int <= 1'b0;
            dma_writeM  <= 1'b0;
            dma_address <= '0;
            dma_data    <= '0;
        end else begin
            dma_end_int <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd) begin
                        addr_r  <= cmd_addr;
                        remain  <= cmd_bursts;
                        dev_idx <= '0;
                        if (cmd_bursts == '0) begin
                            state       <= DONE;
                            dma_end_int <= 1'b1;
                        end else begin
                            state <= REQ;
                            BR    <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (BG) begin
                        state       <= WRITE;
                        dma_address <= addr_r;
                        dma_data    <= dev_data;
                        dma_writeM  <= 1'b1;
                    end
                end
                WRITE: begin
                    // Address, data and strobe stay frozen until memory acknowledges.
                    if (dma_doneWrite) begin
                        dma_writeM <= 1'b0;
                        addr_r     <= addr_r + WORD_SIZE'(BURST_WORDS);
                        remain     <= remain - CW'(1);
                        dev_idx    <= dev_idx + IW'(1);
                        if (remain == CW'(1)) begin
                            state <= RELEASE;
                            BR    <= 1'b0;
                        end else begin
                            state <= NEXT;
                        end
                    end
                end
                NEXT: begin
                    state       <= WRITE;
                    dma_address <= addr_r;
                    dma_data    <= dev_data;
                    dma_writeM  <= 1'b1;
                end
                RELEASE: begin
                    if (!BG) begin
                        state       <= DONE;
                        dma_end_int <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    BR    <= 1'b0;
                end
            endcase
        end
    end

endmodule
